// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the Dijkstra memory-port arbiter.
package dijkstra_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_t;

  // One latched memory command.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
// master: the arbiter's view; slave: the surrounding environment's view.
interface mem_port_arbiter_if
  import dijkstra_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);

  logic                      algorithm_enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_error;
  logic                      busy;
  logic                      mem_read_enable;
  logic                      mem_write_enable;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_write_data;
  logic [DATA_W-1:0]         mem_read_data;
  logic                      mem_read_ready;
  logic                      mem_write_ready;
  logic                      wait_request;

  modport master (
    input  algorithm_enable, req_valid, req_write, req_addr, req_wdata,
    input  mem_read_data, mem_read_ready, mem_write_ready, wait_request,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
    output mem_read_enable, mem_write_enable, mem_addr, mem_write_data
  );

  modport slave (
    output algorithm_enable, req_valid, req_write, req_addr, req_wdata,
    output mem_read_data, mem_read_ready, mem_write_ready, wait_request,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
    input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// i_last_grant, wrapping around; requester i_last_grant itself is checked last.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdxW-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IdxW-1:0]    o_idx
);

  // Scan NUM_REQ positions starting at last_grant+1 and keep the first hit.
  always_comb begin
    logic          found;
    logic [IdxW:0] pos;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      pos = {1'b0, i_last_grant} + (IdxW + 1)'(k);
      if (pos >= (IdxW + 1)'(NUM_REQ)) begin
        pos = pos - (IdxW + 1)'(NUM_REQ);
      end
      if (!found && i_req[pos[IdxW-1:0]]) begin
        found                   = 1'b1;
        o_grant[pos[IdxW-1:0]]  = 1'b1;
        o_idx                   = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters,
// with a per-transaction timeout so a dead memory cannot stall the algorithm.
// The latched command uses the package struct, so ADDR_W/DATA_W are expected
// to stay at the package defaults.
module mem_port_arbiter
  import dijkstra_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                algorithm_clock,
  input  logic                algorithm_reset,
  mem_port_arbiter_if.master  bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value seen in the last allowed ISSUE cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  mem_req_t           r_req;
  mem_req_t           w_sel_req;
  logic [IdxW-1:0]    r_idx;
  logic [IdxW-1:0]    r_last_grant;
  logic [CntW-1:0]    r_cnt;
  logic               r_rd_en;
  logic               r_wr_en;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_error;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IdxW-1:0]    w_pick_idx;
  logic               w_accept;
  logic               w_done;
  logic               w_timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_grant),
    .o_idx        (w_pick_idx)
  );

  // Mux the winning requester's command; reads carry zero write data.
  always_comb begin
    w_sel_req = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_pick_grant[i]) begin
        w_sel_req.write = bus.req_write[i];
        w_sel_req.addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_req.wdata = bus.req_write[i] ? bus.req_wdata[i*DATA_W +: DATA_W] : '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
    if (!algorithm_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus accept/completion/timeout decisions.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_accept = bus.algorithm_enable && (|bus.req_valid) && !bus.wait_request;
        if (w_accept) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_done    = r_req.write ? bus.mem_write_ready : bus.mem_read_ready;
        // A ready in the final cycle takes priority over the abort.
        w_timeout = (TIMEOUT_CYCLES != 0) && !w_done && (r_cnt == CntLast);
        if (w_done || w_timeout) begin
          w_state_next = IDLE;
        end
      end
    endcase
  end

  // Datapath: latch the command on accept, drive the port, emit the response.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
    if (!algorithm_reset) begin
      r_req        <= '0;
      r_idx        <= '0;
      r_last_grant <= IdxW'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_error  <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_req        <= w_sel_req;
        r_idx        <= w_pick_idx;
        r_last_grant <= w_pick_idx;
        r_cnt        <= '0;
        r_rd_en      <= !w_sel_req.write;
        r_wr_en      <= w_sel_req.write;
      end else if (r_state == ISSUE) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_done || w_timeout) begin
          r_rd_en            <= 1'b0;
          r_wr_en            <= 1'b0;
          r_rsp_valid[r_idx] <= 1'b1;
          r_rsp_rdata        <= (w_done && !r_req.write) ? bus.mem_read_data : '0;
          r_rsp_error        <= w_timeout;
        end
      end
    end
  end

  assign bus.req_ready        = w_accept ? w_pick_grant : '0;
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_rdata        = r_rsp_rdata;
  assign bus.rsp_error        = r_rsp_error;
  assign bus.busy             = (r_state == ISSUE);
  assign bus.mem_read_enable  = r_rd_en;
  assign bus.mem_write_enable = r_wr_en;
  assign bus.mem_addr         = r_req.addr;
  assign bus.mem_write_data   = r_req.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (2 requesters, timeout of 8 cycles).
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  mem_port_arbiter_if #(
    .NUM_REQ (2),
    .ADDR_W  (32),
    .DATA_W  (16)
  ) bus ();

  mem_port_arbiter #(
    .NUM_REQ        (2),
    .ADDR_W         (32),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .algorithm_clock (clk),
    .algorithm_reset (rst_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.algorithm_enable = 1'b0;
    bus.req_valid        = '0;
    bus.req_write        = '0;
    bus.req_addr         = '0;
    bus.req_wdata        = '0;
    bus.mem_read_data    = '0;
    bus.mem_read_ready   = 1'b0;
    bus.mem_write_ready  = 1'b0;
    bus.wait_request     = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_rd_en", bus.mem_read_enable, 0);
    check_eq("rst_wr_en", bus.mem_write_enable, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("rst_rsp_error", bus.rsp_error, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single read, memory ready in the third enable cycle
    bus.algorithm_enable = 1'b1;
    bus.req_valid        = 2'b01;
    bus.req_addr[31:0]   = 32'h100;
    settle();
    check_eq("t1_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'hBEEF;
      end
      settle();
      if (bus.mem_read_enable) begin
        cnt++;
        check_eq("t1_mem_addr", bus.mem_addr, 32'h100);
      end
      if (!bus.busy) break;
      check_eq("t1_no_ready", bus.req_ready, 0);
      tick();
      bus.mem_read_ready = 1'b0;
    end
    check_eq("t1_en_cycles", cnt, 3);
    check_eq("t1_rsp_valid", bus.rsp_valid, 2'b01);
    check_eq("t1_rsp_rdata", bus.rsp_rdata, 16'hBEEF);
    check_eq("t1_rsp_error", bus.rsp_error, 0);
    tick();
    check_eq("t1_rsp_pulse", bus.rsp_valid, 0);
    check_eq("t1_rdata_hold", bus.rsp_rdata, 16'hBEEF);

    // Fairness after a fresh reset: 0,1,0,1 with accepts every 2 cycles
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    tick();
    bus.req_valid       = 2'b11;
    bus.req_addr[31:0]  = 32'h200;
    bus.req_addr[63:32] = 32'h300;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      check_eq("t2_grant", bus.req_ready, exp_g);
      tick();
      check_eq("t2_mem_addr", bus.mem_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = 16'h1000 + 16'(k);
      tick();
      bus.mem_read_ready = 1'b0;
      if (k == 3) bus.req_valid = '0;
      settle();
      check_eq("t2_rsp_valid", bus.rsp_valid, exp_g);
      check_eq("t2_rsp_rdata", bus.rsp_rdata, 16'h1000 + 16'(k));
    end
    check_eq("t2_idle_ready", bus.req_ready, 0);
    check_eq("t2_idle_busy", bus.busy, 0);
    tick();

    // Timeout after 8 enable cycles with no ready
    bus.req_valid      = 2'b01;
    bus.req_addr[31:0] = 32'h40;
    settle();
    check_eq("t4_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (bus.mem_read_enable) cnt++;
      if (!bus.busy) break;
      tick();
    end
    check_eq("t4_en_cycles", cnt, 8);
    check_eq("t4_rsp_valid", bus.rsp_valid, 2'b01);
    check_eq("t4_rsp_error", bus.rsp_error, 1);
    check_eq("t4_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("t4_busy", bus.busy, 0);
    tick();

    // Ready in the final allowed cycle beats the timeout
    bus.req_valid      = 2'b01;
    bus.req_addr[31:0] = 32'h44;
    settle();
    check_eq("t4b_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 7; i++) tick();
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h5A5A;
    settle();
    check_eq("t4b_en_last", bus.mem_read_enable, 1);
    tick();
    bus.mem_read_ready = 1'b0;
    check_eq("t4b_rsp_valid", bus.rsp_valid, 2'b01);
    check_eq("t4b_rsp_error", bus.rsp_error, 0);
    check_eq("t4b_rsp_rdata", bus.rsp_rdata, 16'h5A5A);
    tick();

    // Write under backpressure, stray read ready ignored
    bus.mem_read_data    = 16'hAAAA;
    bus.req_valid        = 2'b10;
    bus.req_write        = 2'b10;
    bus.req_addr[63:32]  = 32'h20;
    bus.req_wdata[31:16] = 16'h1234;
    bus.wait_request     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("t3_wait_ready", bus.req_ready, 0);
      check_eq("t3_wait_busy", bus.busy, 0);
      tick();
    end
    bus.wait_request = 1'b0;
    settle();
    check_eq("t3_req_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid    = '0;
    bus.wait_request = 1'b1;
    check_eq("t3_wr_en", bus.mem_write_enable, 1);
    check_eq("t3_rd_en", bus.mem_read_enable, 0);
    check_eq("t3_mem_addr", bus.mem_addr, 32'h20);
    check_eq("t3_mem_wdata", bus.mem_write_data, 16'h1234);
    bus.mem_read_ready = 1'b1;
    tick();
    bus.mem_read_ready = 1'b0;
    check_eq("t3_stray_busy", bus.busy, 1);
    check_eq("t3_stray_wr_en", bus.mem_write_enable, 1);
    check_eq("t3_stray_rsp", bus.rsp_valid, 0);
    bus.mem_write_ready = 1'b1;
    tick();
    bus.mem_write_ready = 1'b0;
    bus.wait_request    = 1'b0;
    bus.req_write       = '0;
    check_eq("t3_rsp_valid", bus.rsp_valid, 2'b10);
    check_eq("t3_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("t3_rsp_error", bus.rsp_error, 0);
    check_eq("t3_wr_en_off", bus.mem_write_enable, 0);
    tick();

    // Reset asserted mid-ISSUE
    bus.req_valid      = 2'b01;
    bus.req_addr[31:0] = 32'h200;
    settle();
    check_eq("t5_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    check_eq("t5_rd_en", bus.mem_read_enable, 1);
    settle();
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_rd_en", bus.mem_read_enable, 0);
    check_eq("t5_async_busy", bus.busy, 0);
    check_eq("t5_async_rsp", bus.rsp_valid, 0);
    bus.req_valid = 2'b11;
    tick();
    tick();
    check_eq("t5_hold_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    settle();
    check_eq("t5_first_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    check_eq("t5_mem_addr", bus.mem_addr, 32'h200);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h0F0F;
    tick();
    bus.mem_read_ready = 1'b0;
    check_eq("t5_rsp_valid", bus.rsp_valid, 2'b01);
    tick();

    // Enable gating
    bus.algorithm_enable = 1'b0;
    bus.req_valid        = 2'b01;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("t6_gated_ready", bus.req_ready, 0);
      check_eq("t6_gated_busy", bus.busy, 0);
      tick();
    end
    bus.algorithm_enable = 1'b1;
    settle();
    check_eq("t6_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.algorithm_enable = 1'b0;
    check_eq("t6_rd_en", bus.mem_read_enable, 1);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h1111;
    tick();
    bus.mem_read_ready = 1'b0;
    check_eq("t6_rsp_valid", bus.rsp_valid, 2'b01);
    check_eq("t6_rsp_rdata", bus.rsp_rdata, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("t6_after_ready", bus.req_ready, 0);
      check_eq("t6_after_busy", bus.busy, 0);
      tick();
    end
    bus.req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single Dijkstra memory port (read/write enables, 32-bit address, 16-bit data, ready/wait_request handshake) between NUM_REQ algorithm-side requesters, e.g. node-fetch and distance-writeback units.
- Grants one transaction at a time in round-robin order, drives the memory port, and returns a per-requester completion pulse with read data.
- A timeout guard keeps a dead memory from hanging the algorithm.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 16, data width
- TIMEOUT_CYCLES, 1024, maximum cycles in ISSUE before abort; 0 disables the timeout

Ports:
- algorithm_clock  in  1  sole clock
- algorithm_reset  in  1  asynchronous, active-low reset
- algorithm_enable  in  1  when low, no new grants are made
- req_valid  in  NUM_REQ  per-requester request
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i is slice i
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot accept; combinational
- rsp_valid  out  NUM_REQ  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid
- rsp_error  out  1  timeout flag; valid with rsp_valid
- busy  out  1  high while in ISSUE
- mem_read_enable  out  1
- mem_write_enable  out  1
- mem_addr  out  ADDR_W
- mem_write_data  out  DATA_W
- mem_read_data  in  DATA_W
- mem_read_ready  in  1  read-complete strobe
- mem_write_ready  in  1  write-complete strobe
- wait_request  in  1  memory not accepting new commands

Behaviour:
- Reset (algorithm_reset = 0) takes effect immediately and asynchronously: state IDLE; every registered output is 0; last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- Reset asserted mid-ISSUE abandons the transaction: enables drop at once and no rsp_valid is produced.
- FSM has two states, IDLE and ISSUE.
- IDLE, accept condition: algorithm_enable && |req_valid && !wait_request.
  - Pick the first valid requester searching from (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - req_ready[idx] is high combinationally in that same cycle.
  - At the clock edge: latch addr, wdata, write and idx; set last_grant = idx; clear the timeout counter; go to ISSUE.
- ISSUE, port drive:
  - mem_read_enable or mem_write_enable (per the latched write bit) is high from the cycle after accept.
  - mem_addr and mem_write_data are held stable throughout.
  - mem_write_data = 0 for reads.
- ISSUE, completion: the matching ready (mem_read_ready for reads, mem_write_ready for writes) is sampled high at an edge. On that edge:
  - deassert the enable;
  - rsp_valid[idx] <= 1 for exactly one cycle;
  - rsp_rdata <= mem_read_data for reads, 0 for writes;
  - rsp_error <= 0;
  - return to IDLE.
- ISSUE, other inputs: the non-matching ready is ignored. wait_request is ignored in ISSUE; it only gates new grants.
- ISSUE, timeout: the counter increments every ISSUE cycle. If TIMEOUT_CYCLES ≠ 0 and the enable has been high TIMEOUT_CYCLES cycles with no matching ready:
  - abort, with the enable dropping after exactly TIMEOUT_CYCLES cycles;
  - rsp_valid[idx] pulses with rsp_error = 1 and rsp_rdata = 0;
  - return to IDLE.
  - A ready arriving in the final cycle wins over the timeout.
- Latency: accept at edge N; enable high from cycle N+1; ready at edge M; rsp_valid high in cycle M+1. The next accept may occur in cycle M+1, concurrent with rsp_valid. The minimum accept-to-accept spacing is 2 cycles.
- Enable gating: algorithm_enable low in IDLE blocks grants. Dropping algorithm_enable during ISSUE does not abort; the transaction completes.
- Requester rules: a requester may re-assert or hold req_valid during its own rsp_valid. Between rsp_valid and a new acceptance, requesters hold req_addr and req_wdata stable while req_valid is high.
- busy = (state == ISSUE).
- rsp_rdata and rsp_error hold their last values when rsp_valid is 0.

Decomposition:
- Package dijkstra_mem_pkg holds:
  - ADDR_W/DATA_W default constants;
  - typedef enum logic {IDLE, ISSUE} arb_state_t;
  - typedef struct packed {logic write; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} mem_req_t.
- Sub-module rr_pick: combinational round-robin picker. Inputs req vector and last_grant; outputs one-hot grant and index. Instantiated once.

Test Plan:
- Single read: req_valid[0] = 1, addr 0x100; memory raises mem_read_ready 3 cycles after the enable, with data 0xBEEF. Required: req_ready[0] pulses 1 cycle; mem_read_enable is high 3 cycles at addr 0x100; rsp_valid[0] pulses once with rsp_rdata = 0xBEEF and rsp_error = 0.
- Fairness: both requesters valid continuously after reset, memory ready after 1 cycle. Required: grant order 0,1,0,1,…; accepts every 2 cycles.
- Write under backpressure: req_valid[1] with write, addr 0x20, data 0x1234, and wait_request high for the first 4 cycles. Required: no req_ready while wait_request is high; then mem_write_enable with 0x1234 at 0x20. A stray mem_read_ready pulse is ignored. Completion occurs only on mem_write_ready; rsp_rdata = 0.
- Timeout: TIMEOUT_CYCLES = 8 and no ready. Required: enable high exactly 8 cycles; rsp_valid[0] with rsp_error = 1 and rsp_rdata = 0; busy falls.
- Reset mid-ISSUE: algorithm_reset pulled low during a read. Required: enables, busy and rsp_valid are 0 asynchronously; after release, with both requesting, requester 0 is granted first.
- Enable gating: algorithm_enable = 0 with req_valid high gives no grant. Raise it, grant, then drop it mid-ISSUE. Required: the transaction completes with rsp_valid, and no further grant is made.
